// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports (port 1 wins on collision), NR combinational
// read ports, optional write-to-read bypass, synchronous bulk clear and hardwired-zero entry 0.
module register_file_mp #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int NR      = 2,
    parameter int BYPASS  = 0,
    parameter int ZERO_R0 = 1
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wen0,
    input  logic [AW-1:0]    waddr0,
    input  logic [DW-1:0]    wdata0,
    input  logic             wen1,
    input  logic [AW-1:0]    waddr1,
    input  logic [DW-1:0]    wdata1,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic             wcollide
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_reg [DEPTH];
    logic          wcollide_reg;
    logic          w0_live;
    logic          w1_live;
    logic          collide_next;

    // A write is live unless it targets the hardwired-zero entry.
    always_comb begin
        w0_live      = wen0 && !((ZERO_R0 != 0) && (waddr0 == '0));
        w1_live      = wen1 && !((ZERO_R0 != 0) && (waddr1 == '0));
        collide_next = !clr && w0_live && w1_live && (waddr0 == waddr1);
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wcollide_reg <= 1'b0;
        end else begin
            wcollide_reg <= collide_next;
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_reg[i] <= '0;
                end
            end else begin
                if (w0_live) begin
                    mem_reg[waddr0] <= wdata0;
                end
                // Issued after port 0 so port 1 overrides it on a shared address.
                if (w1_live) begin
                    mem_reg[waddr1] <= wdata1;
                end
            end
        end
    end

    assign wcollide = wcollide_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NR; gi++) begin : g_rd
            logic [AW-1:0] rd_addr;
            logic [DW-1:0] rd_val;

            assign rd_addr = raddr[gi*AW +: AW];

            // Forwarding is disabled during reset and clear so those always read as zero/stored.
            always_comb begin
                rd_val = mem_reg[rd_addr];
                if ((BYPASS != 0) && rst_n && !clr) begin
                    if (wen1 && (waddr1 == rd_addr)) begin
                        rd_val = wdata1;
                    end else if (wen0 && (waddr0 == rd_addr)) begin
                        rd_val = wdata0;
                    end
                end
                if ((ZERO_R0 != 0) && (rd_addr == '0)) begin
                    rd_val = '0;
                end
            end

            assign rdata[gi*DW +: DW] = rd_val;
        end
    endgenerate

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parameterised multi-port register file for the datapath. It generalises the 8-entry, 8-bit, 1-write/2-read register file to configurable width, depth and read-port count, and adds a second write port with defined collision priority, an optional write-to-read bypass and a synchronous bulk clear. Entry 0 can be hardwired to zero. The block sits between the decode stage (read addresses) and the writeback stage (write ports).

## Interface
- DW, 8: data width in bits.
- AW, 3: address width; depth = 2^AW entries.
- NR, 2: number of read ports (1..8).
- BYPASS, 0: 1 = a same-cycle write to the addressed entry is forwarded to the read port; 0 = reads return the stored value.
- ZERO_R0, 1: 1 = entry 0 always reads 0 and ignores writes.
- Clk  in  1  clock; all writes occur on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; clears every entry to 0.
- clr  in  1  synchronous clear of all entries; takes priority over both write ports.
- wen0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  DW  write data, port 0.
- wen1  in  1  write enable, port 1.
- waddr1  in  AW  write address, port 1.
- wdata1  in  DW  write data, port 1.
- raddr  in  NR*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rdata  out  NR*DW  packed read data; port k uses bits [k*DW +: DW].
- wcollide  out  1  registered flag: on the previous edge, wen0 and wen1 were both set to the same, non-suppressed address.

## Operation
- Storage: 2^AW entries of DW bits.
- Reads:
  - Combinational, with no read enable.
  - rdata[k] = entry[raddr[k]].
  - With ZERO_R0=1, rdata[k] = 0 whenever raddr[k] = 0, regardless of writes or bypass.
- Writes, at posedge Clk:
  - Port 0 writes wdata0 to waddr0 when wen0=1.
  - Port 1 writes wdata1 to waddr1 when wen1=1.
  - Different addresses: both writes commit in the same edge.
  - Same address, both enabled: port 1 wins, and wcollide is 1 in the following cycle.
- Suppression:
  - With ZERO_R0=1, writes to address 0 are dropped and never raise wcollide.
  - clr=1: all entries become 0 at the edge, both write ports are ignored, and wcollide is 0 in the following cycle.
- Bypass (BYPASS=1), evaluated per read port:
  - If wen1 && waddr1==raddr[k], then rdata[k]=wdata1.
  - Else if wen0 && waddr0==raddr[k], then rdata[k]=wdata0.
  - Else rdata[k] is the stored value.
  - Suppression overrides bypass: when clr=1, and for address 0 when ZERO_R0=1, the stored or zero value is returned.
- Widths: data is stored and returned unmodified, with no extension or truncation. Any address in 0..2^AW-1 is legal.

## Timing
- Reset:
  - rst_n low immediately forces all entries to 0 and wcollide to 0, independent of Clk.
  - rdata therefore reads 0 on every port during reset.
  - Write enables are ignored while rst_n=0.
- Release: the first write takes effect on the first rising edge after rst_n goes high.
- Write-to-read latency, BYPASS=0:
  - A write at edge N is visible on rdata after edge N, within the same cycle through combinational settle.
  - During the cycle before edge N, the old value is returned.
- Write-to-read latency, BYPASS=1: rdata shows the write data during the same cycle in which wen is asserted, before the edge.
- wcollide: registered; it describes the previous edge only and holds for exactly one cycle per collision.
- Reset asserted mid-cycle with writes pending: the writes are lost and the entries stay 0.

## Test plan
- Reset/fill/readback, with DW=8, AW=3, NR=2, ZERO_R0=1:
  - Stimulus: assert reset; write random patterns p[0..7] to addresses 0..7 over 8 cycles; then sweep RX=0..7 on port 0, then sweep port 1.
  - Required response: address 0 reads 0, and address a reads p[a] for a=1..7 on both ports.
- Dual-write collision:
  - Stimulus: wen0=wen1=1, waddr0=waddr1=5, wdata0=8'hAA, wdata1=8'h55.
  - Required response: entry 5 = 8'h55 after the edge; wcollide=1 for exactly one cycle.
  - Follow-up: repeat with address 0 and ZERO_R0=1; the entry stays 0 and wcollide=0.
- Parallel writes:
  - Stimulus: wen0 to address 2 with 8'h12, wen1 to address 3 with 8'h34, in the same edge.
  - Required response: both values read back; wcollide=0.
- Bypass (BYPASS=1):
  - Stimulus: wen1=1, waddr1=4, wdata1=8'hC3, raddr port 0=4, observed before the edge.
  - Required response: rdata port 0 = 8'hC3.
  - Follow-up: with BYPASS=0, the old value is returned until after the edge.
- Clear priority:
  - Stimulus: fill all entries, then assert clr=1 with wen0=1, waddr0=6, wdata0=8'hFF.
  - Required response: all entries are 0 after the edge, including entry 6.
- Asynchronous reset mid-operation:
  - Stimulus: pulse rst_n low between edges while wen0=1.
  - Required response: rdata is 0 immediately on all ports; no write commits; wcollide=0.
  - Parameter sweep: rerun scenarios 1–2 with DW=16, AW=4, NR=3.
